// File: rtl/arp_rx_parser_if.sv
// Byte-stream bus between the MAC RX path and the ARP receive parser.
// The master drives the received bytes and the local address; the parser (slave) returns the results.
interface arp_rx_parser_if;
  logic        data_valid;
  logic [7:0]  data_rx;
  logic [47:0] my_mac;
  logic [31:0] my_ip;
  logic        send_mac;
  logic [47:0] source_mac;
  logic [31:0] source_ip;
  logic        frame_drop;

  modport master (
    output data_valid, data_rx, my_mac, my_ip,
    input  send_mac, source_mac, source_ip, frame_drop
  );

  modport slave (
    input  data_valid, data_rx, my_mac, my_ip,
    output send_mac, source_mac, source_ip, frame_drop
  );
endinterface

// File: rtl/arp_rx_parser.sv
// Receive-side ARP engine: parses an Ethernet byte stream and reports ARP requests for my_ip.
// state | meaning
// IDLE  | waiting for the first byte of a frame (only after the line has been seen idle)
// PARSE | checking bytes 1..41 against the ARP request map, capturing SHA/SPA
// MATCH | one cycle with send_mac high and source_mac/source_ip freshly loaded
// DRAIN | discarding the rest of the frame until data_valid drops
module arp_rx_parser #(
  parameter bit CHECK_DEST = 1'b1
) (
  input  logic        clk,
  input  logic        areset,
  arp_rx_parser_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PARSE, MATCH, DRAIN} state_t;

  state_t      state_q;
  logic [5:0]  idx_q;
  logic        armed_q;
  logic        bcast_q;
  logic        mine_q;
  logic [47:0] sha_q;
  logic [31:0] spa_q;
  logic        send_q;
  logic        drop_q;
  logic [47:0] src_mac_q;
  logic [31:0] src_ip_q;

  logic [7:0]  mac_byte;
  logic [7:0]  ip_byte;
  logic        bcast_d;
  logic        mine_d;
  logic        byte_ok;

  always_comb begin
    mac_byte = 8'h00;
    case (idx_q)
      6'd0:    mac_byte = bus.my_mac[47:40];
      6'd1:    mac_byte = bus.my_mac[39:32];
      6'd2:    mac_byte = bus.my_mac[31:24];
      6'd3:    mac_byte = bus.my_mac[23:16];
      6'd4:    mac_byte = bus.my_mac[15:8];
      6'd5:    mac_byte = bus.my_mac[7:0];
      default: mac_byte = 8'h00;
    endcase

    ip_byte = 8'h00;
    case (idx_q)
      6'd38:   ip_byte = bus.my_ip[31:24];
      6'd39:   ip_byte = bus.my_ip[23:16];
      6'd40:   ip_byte = bus.my_ip[15:8];
      6'd41:   ip_byte = bus.my_ip[7:0];
      default: ip_byte = 8'h00;
    endcase

    // Running per-byte match of the destination against broadcast and our own MAC.
    bcast_d = ((state_q == IDLE) || bcast_q) && (bus.data_rx == 8'hFF);
    mine_d  = ((state_q == IDLE) || mine_q) && (bus.data_rx == mac_byte);

    byte_ok = 1'b1;
    case (idx_q)
      6'd5:                       byte_ok = !CHECK_DEST || bcast_d || mine_d;
      6'd12, 6'd16:               byte_ok = (bus.data_rx == 8'h08);
      6'd13, 6'd18:               byte_ok = (bus.data_rx == 8'h06);
      6'd14, 6'd17, 6'd20:        byte_ok = (bus.data_rx == 8'h00);
      6'd15, 6'd21:               byte_ok = (bus.data_rx == 8'h01);
      6'd19:                      byte_ok = (bus.data_rx == 8'h04);
      6'd38, 6'd39, 6'd40, 6'd41: byte_ok = (bus.data_rx == ip_byte);
      default:                    byte_ok = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!areset) begin
      state_q   <= IDLE;
      idx_q     <= 6'd0;
      // A frame still in flight at reset release must be drained, not parsed from its middle.
      armed_q   <= !bus.data_valid;
      bcast_q   <= 1'b0;
      mine_q    <= 1'b0;
      sha_q     <= 48'h0;
      spa_q     <= 32'h0;
      send_q    <= 1'b0;
      drop_q    <= 1'b0;
      src_mac_q <= 48'h0;
      src_ip_q  <= 32'h0;
    end else begin
      send_q <= 1'b0;
      drop_q <= 1'b0;
      if (!bus.data_valid) armed_q <= 1'b1;

      case (state_q)
        IDLE: begin
          idx_q <= 6'd0;
          if (bus.data_valid && armed_q) begin
            idx_q   <= 6'd1;
            bcast_q <= bcast_d;
            mine_q  <= mine_d;
            state_q <= PARSE;
          end
        end

        PARSE: begin
          if (!bus.data_valid) begin
            drop_q  <= 1'b1;
            idx_q   <= 6'd0;
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q + 6'd1;
            bcast_q <= bcast_d;
            mine_q  <= mine_d;
            if (idx_q >= 6'd22 && idx_q <= 6'd27) sha_q <= {sha_q[39:0], bus.data_rx};
            if (idx_q >= 6'd28 && idx_q <= 6'd31) spa_q <= {spa_q[23:0], bus.data_rx};
            if (!byte_ok) begin
              drop_q  <= 1'b1;
              state_q <= DRAIN;
            end else if (idx_q == 6'd41) begin
              send_q    <= 1'b1;
              src_mac_q <= sha_q;
              src_ip_q  <= spa_q;
              state_q   <= MATCH;
            end
          end
        end

        MATCH, DRAIN: begin
          // MATCH exits straight to IDLE on a 42-byte frame so a frame one idle cycle later is caught.
          if (bus.data_valid) begin
            if (idx_q != 6'd42) idx_q <= idx_q + 6'd1;
            state_q <= DRAIN;
          end else begin
            idx_q   <= 6'd0;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.send_mac   = send_q;
  assign bus.frame_drop = drop_q;
  assign bus.source_mac = src_mac_q;
  assign bus.source_ip  = src_ip_q;

endmodule
